// File: rtl/gmii_frame_dispatcher.sv
// Per-port GMII dispatcher: parses the DA, queues a per-frame output mask and replays the stream
// through a fixed delay line. Define GMII_DISPATCH_STATS_EN to build the forward/drop frame counters.
module gmii_frame_dispatcher #(
  parameter int N_OUT = 3,
  parameter int DELAY = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_dv,
  input  logic               rx_er,
  input  logic [N_OUT*48-1:0] mac_table,
  input  logic [N_OUT-1:0]   mac_valid,
  output logic [7:0]         out_data,
  output logic               out_er,
  output logic [N_OUT-1:0]   out_dv,
  output logic [31:0]        stat_fwd,
  output logic [31:0]        stat_drop
);

  typedef enum logic [2:0] {S_WAIT_END, S_IDLE, S_PRE, S_DST, S_FWD, S_DROP} state_t;

  // sof marks the first byte of a frame the parser has counted, so only those pop a mask
  typedef struct packed {
    logic       sof;
    logic [7:0] data;
    logic       dv;
    logic       er;
  } stage_t;

  stage_t             r_dly [DELAY];
  state_t             r_state, w_state_next;
  logic [2:0]         r_idx, w_idx_next;
  logic [2:0]         r_da_cnt, w_da_cnt_next;
  logic [39:0]        r_da, w_da_next;
  logic [47:0]        w_da;
  logic               w_sof, w_push, w_pop, w_found;
  logic [N_OUT-1:0]   w_push_mask, w_hit, w_lookup;
  logic [N_OUT-1:0]   r_fifo [8];
  logic [2:0]         r_wr_ptr, r_rd_ptr;
  logic [N_OUT-1:0]   r_cur_mask;
  logic               w_unused_sof;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DELAY; i++) r_dly[i] <= '0;
    end else begin
      r_dly[0] <= '{sof: w_sof, data: rx_data, dv: rx_dv, er: rx_er};
      for (int i = 1; i < DELAY; i++) r_dly[i] <= r_dly[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_WAIT_END;
      r_idx    <= '0;
      r_da_cnt <= '0;
      r_da     <= '0;
    end else begin
      r_state  <= w_state_next;
      r_idx    <= w_idx_next;
      r_da_cnt <= w_da_cnt_next;
      r_da     <= w_da_next;
    end
  end

  assign w_da = {r_da, rx_data};

  always_comb begin
    w_hit   = '0;
    w_found = 1'b0;
    for (int k = 0; k < N_OUT; k++) begin
      if (!w_found && mac_valid[k] && mac_table[48*k +: 48] == w_da) begin
        w_hit[k] = 1'b1;
        w_found  = 1'b1;
      end
    end
    w_lookup = (w_da[40] || !w_found) ? '1 : w_hit;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next  = r_state;
    w_idx_next    = r_idx;
    w_da_cnt_next = r_da_cnt;
    w_da_next     = r_da;
    w_push        = 1'b0;
    w_push_mask   = '0;
    w_sof         = 1'b0;
    case (r_state)
      S_WAIT_END: if (!rx_dv) w_state_next = S_IDLE;
      S_IDLE: begin
        if (rx_dv) begin
          w_sof = 1'b1;
          if (rx_data == 8'hD5) begin
            w_state_next  = S_DST;
            w_da_cnt_next = '0;
          end else begin
            w_state_next = S_PRE;
            w_idx_next   = 3'd1;
          end
        end
      end
      S_PRE: begin
        if (!rx_dv) begin
          w_push       = 1'b1;
          w_state_next = S_IDLE;
        end else if (rx_data == 8'hD5) begin
          w_state_next  = S_DST;
          w_da_cnt_next = '0;
        end else if (r_idx == 3'd7) begin
          w_state_next = S_DROP;
        end else begin
          w_idx_next = r_idx + 3'd1;
        end
      end
      S_DST: begin
        if (!rx_dv) begin
          w_push       = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_da_next = {r_da[31:0], rx_data};
          if (r_da_cnt == 3'd5) begin
            w_push       = 1'b1;
            w_push_mask  = w_lookup;
            w_state_next = S_FWD;
          end else begin
            w_da_cnt_next = r_da_cnt + 3'd1;
          end
        end
      end
      S_FWD: if (!rx_dv) w_state_next = S_IDLE;
      S_DROP: begin
        if (!rx_dv) begin
          w_push       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_WAIT_END;
    endcase
  end

  // NOTE: the FIFO storage is not reset; the pointers alone define emptiness.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_push_mask;
  end

  // Pop one stage early so the registered mask lines up with the first delayed byte.
  assign w_pop = r_dly[DELAY-2].sof;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cur_mask <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 3'd1;
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + 3'd1;
        r_cur_mask <= r_fifo[r_rd_ptr];
      end else if (r_dly[DELAY-1].dv && !r_dly[DELAY-2].dv) begin
        r_cur_mask <= '0;
      end
    end
  end

  assign out_data     = r_dly[DELAY-1].data;
  assign out_dv       = {N_OUT{r_dly[DELAY-1].dv}} & r_cur_mask;
  assign out_er       = r_dly[DELAY-1].er & (|r_cur_mask);
  assign w_unused_sof = r_dly[DELAY-1].sof;

`ifdef GMII_DISPATCH_STATS_EN
  logic [31:0] r_stat_fwd, r_stat_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_fwd  <= '0;
      r_stat_drop <= '0;
    end else if (w_push) begin
      if (|w_push_mask) begin
        if (r_stat_fwd != 32'hFFFF_FFFF) r_stat_fwd <= r_stat_fwd + 32'd1;
      end else begin
        if (r_stat_drop != 32'hFFFF_FFFF) r_stat_drop <= r_stat_drop + 32'd1;
      end
    end
  end

  assign stat_fwd  = r_stat_fwd;
  assign stat_drop = r_stat_drop;
`else
  assign stat_fwd  = '0;
  assign stat_drop = '0;
`endif

endmodule

// File: tb/tb_gmii_frame_dispatcher.sv
// Directed bench for gmii_frame_dispatcher: logs every cycle of input and output, then checks
// each frame's mask, latency, length, data replay and error forwarding against hand-derived values.
module tb_gmii_frame_dispatcher;

  localparam int N_OUT = 3;
  localparam int MAXC  = 2048;
  localparam logic [47:0] MAC0  = 48'h02_00_00_00_00_10;
  localparam logic [47:0] MAC1  = 48'h02_00_00_00_00_01;
  localparam logic [47:0] MAC2  = 48'h02_00_00_00_00_02;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] UNK   = 48'h02_00_00_00_00_77;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [7:0]           rx_data;
  logic                 rx_dv, rx_er;
  logic [N_OUT*48-1:0]  mac_table;
  logic [N_OUT-1:0]     mac_valid;
  logic [7:0]           out_data;
  logic                 out_er;
  logic [N_OUT-1:0]     out_dv;
  logic [31:0]          stat_fwd, stat_drop;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]       log_in_d   [MAXC];
  logic [7:0]       log_out_d  [MAXC];
  logic [N_OUT-1:0] log_out_dv [MAXC];
  logic             log_out_er [MAXC];

  gmii_frame_dispatcher #(.N_OUT(N_OUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_dv     (rx_dv),
    .rx_er     (rx_er),
    .mac_table (mac_table),
    .mac_valid (mac_valid),
    .out_data  (out_data),
    .out_er    (out_er),
    .out_dv    (out_dv),
    .stat_fwd  (stat_fwd),
    .stat_drop (stat_drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (cyc < MAXC) begin
      log_in_d[cyc]   = rx_data;
      log_out_d[cyc]  = out_data;
      log_out_dv[cyc] = out_dv;
      log_out_er[cyc] = out_er;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rx_dv = 1'b0; rx_data = 8'h00; rx_er = 1'b0; rst = 1'b0;
    end
  endtask

  // Frame = pre_n x 0x55, optional SFD, then len bytes starting with the DA.
  task automatic send_frame(input int pre_n, input logic sfd, input logic [47:0] da,
                            input int len, input int er_at, input int rst_at, output int start);
    logic [7:0] q[$];
    for (int i = 0; i < pre_n; i++) q.push_back(8'h55);
    if (sfd) q.push_back(8'hD5);
    for (int i = 0; i < len; i++) begin
      if (i < 6) q.push_back(da[47-8*i -: 8]);
      else       q.push_back(8'(i * 7 + 3));
    end
    start = 0;
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk); #1;
      if (i == 0) start = cyc;
      rx_data = q[i];
      rx_dv   = 1'b1;
      rx_er   = (i == er_at);
      rst     = (i == rst_at);
    end
    idle(1);
  endtask

  task automatic check_frame(input string tag, input int s, input int dv, input logic [N_OUT-1:0] mask);
    int n_ok, n_bad_d;
    n_ok = 0;
    n_bad_d = 0;
    check({tag, "_pre"}, log_out_dv[s+14], 0);
    check({tag, "_first"}, log_out_dv[s+15], mask);
    for (int c = s + 15; c < s + 15 + dv; c++) begin
      if (log_out_dv[c] == mask) n_ok++;
      if (log_out_d[c] != log_in_d[c-15]) n_bad_d++;
    end
    check({tag, "_len"}, n_ok, dv);
    check({tag, "_tail"}, log_out_dv[s+15+dv], 0);
    check({tag, "_data"}, n_bad_d, 0);
  endtask

  function automatic int count_er(input int s, input int dv);
    int n = 0;
    for (int c = s + 15; c < s + 15 + dv; c++) if (log_out_er[c]) n++;
    return n;
  endfunction

  initial begin
    int s0, s1, s2, s3, s4, s5, s6, s7, s8, n_live;
    mac_table = {MAC2, MAC1, MAC0};
    mac_valid = 3'b111;
    rst = 1'b1; rx_data = 8'h00; rx_dv = 1'b0; rx_er = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_dv", out_dv, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_er", out_er, 0);
    check("rst_stat_fwd", stat_fwd, 0);
    check("rst_stat_drop", stat_drop, 0);
    idle(5);

    send_frame(7, 1'b1, MAC1, 64, 20, -1, s0);   idle(11);
    send_frame(7, 1'b1, BCAST, 64, -1, -1, s1);  idle(11);
    send_frame(7, 1'b1, UNK, 64, -1, -1, s2);    idle(11);
    send_frame(1, 1'b1, MAC0, 64, -1, -1, s3);   idle(11);
    send_frame(8, 1'b0, MAC1, 60, 20, -1, s4);   idle(11);
    send_frame(7, 1'b1, MAC2, 2, -1, -1, s5);
    send_frame(7, 1'b1, MAC2, 64, -1, -1, s6);
    idle(40);

    check_frame("uni", s0, 72, 3'b010);
    check("uni_er_pos", log_out_er[s0+35], 1);
    check("uni_er_cnt", count_er(s0, 72), 1);
    check_frame("bcast", s1, 72, 3'b111);
    check_frame("unknown", s2, 72, 3'b111);
    check_frame("short_pre", s3, 66, 3'b001);
    check_frame("bad_pre", s4, 68, 3'b000);
    check("bad_pre_er", count_er(s4, 68), 0);
    check_frame("runt", s5, 10, 3'b000);
    check("gap_kept", s6 - s5, 11);
    check_frame("after_runt", s6, 72, 3'b100);
`ifdef GMII_DISPATCH_STATS_EN
    check("stat_fwd", stat_fwd, 5);
    check("stat_drop", stat_drop, 2);
`else
    check("stat_fwd", stat_fwd, 0);
    check("stat_drop", stat_drop, 0);
`endif

    send_frame(7, 1'b1, MAC1, 64, -1, 30, s7);
    @(negedge clk);
    check("rst_mid_stat_fwd", stat_fwd, 0);
    check("rst_mid_stat_drop", stat_drop, 0);
    idle(5);
    send_frame(7, 1'b1, MAC0, 64, -1, -1, s8);
    idle(40);

    check("rst_mid_head", log_out_dv[s7+15], 3'b010);
    n_live = 0;
    for (int c = s7 + 31; c <= s7 + 15 + 72; c++) if (log_out_dv[c] != 0) n_live++;
    check("rst_mid_quiet", n_live, 0);
    check_frame("post_rst", s8, 72, 3'b001);
`ifdef GMII_DISPATCH_STATS_EN
    check("post_rst_stat_fwd", stat_fwd, 1);
`else
    check("post_rst_stat_fwd", stat_fwd, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
